// File: rtl/rtc_i2c_pkg.sv
// Shared encodings for the DS1307 I2C sequencer: FSM states, engine ack codes
// and the transfer-length legality check.
package rtc_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    DEV_W  = 3'd2,
    REG    = 3'd3,
    WDATA  = 3'd4,
    RSTART = 3'd5,
    RDATA  = 3'd6
  } state_t;

  localparam logic [1:0] ACK_OK   = 2'b11;
  localparam logic [1:0] ACK_NACK = 2'b10;
  localparam int         MAX_LEN  = 8;

  function automatic logic len_legal(input logic [3:0] len);
    return (len != 4'd0) && (len <= 4'(MAX_LEN));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester not served last wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt,
  output logic       o_idx
);

  logic r_last;

  // Reset pretends requester 1 was served last so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst)         r_last <= 1'b1;
    else if (i_take) r_last <= o_idx;
  end

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  assign o_idx = o_gnt[1];

endmodule

// File: rtl/rtc_i2c_sequencer.sv
// Two-requester register sequencer for a DS1307 RTC in front of an external
// I2C byte engine: device address, register pointer, then write or read burst.
module rtc_i2c_sequencer
  import rtc_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_reg,
  input  logic [7:0]  req_len,
  input  logic [15:0] wr_byte,
  output logic [1:0]  grant,
  output logic [1:0]  wr_next,
  output logic [7:0]  rd_byte,
  output logic [1:0]  rd_valid,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        i2c_start,
  output logic        i2c_stop,
  output logic [7:0]  i2c_wr_data,
  input  logic        i2c_rd_tick,
  input  logic [1:0]  i2c_ack,
  input  logic [7:0]  i2c_rd_data
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        r_state, w_next;
  logic          r_owner, r_write;
  logic [7:0]    r_reg;
  logic [3:0]    r_cnt;
  logic [TW-1:0] r_tmo;

  logic [1:0] w_arb_gnt, w_own_oh;
  logic       w_arb_idx, w_arb_take;
  logic [3:0] w_arb_len;
  logic       w_len_ok;
  logic       w_ack, w_nack, w_tmo, w_bus_fail, w_rd_fail;
  logic       w_last, w_byte_done, w_active, w_tmo_clr;
  logic [7:0] w_wr_sel;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  (req_valid),
    .i_take (w_arb_take),
    .o_gnt  (w_arb_gnt),
    .o_idx  (w_arb_idx)
  );

  assign w_arb_take = (r_state == ARB) && (w_arb_gnt != 2'b00);
  assign w_arb_len  = w_arb_idx ? req_len[7:4] : req_len[3:0];
  assign w_len_ok   = len_legal(w_arb_len);
  assign w_own_oh   = r_owner ? 2'b10 : 2'b01;
  assign w_wr_sel   = r_owner ? wr_byte[15:8] : wr_byte[7:0];

  assign w_ack    = (i2c_ack == ACK_OK);
  assign w_nack   = (i2c_ack == ACK_NACK);
  assign w_active = (r_state != IDLE) && (r_state != ARB);
  assign w_tmo    = w_active && (r_tmo == TW'(TIMEOUT_CYC - 1));
  // A real ack or data tick in the expiry cycle wins over the timeout.
  assign w_bus_fail = w_nack || (w_tmo && !w_ack);
  assign w_rd_fail  = w_tmo && !i2c_rd_tick;

  assign w_last      = (r_cnt == 4'd1);
  assign w_byte_done = ((r_state == WDATA) && w_ack) ||
                       (((r_state == RSTART) || (r_state == RDATA)) && i2c_rd_tick);
  assign w_tmo_clr   = !w_active || (w_next != r_state) || i2c_ack[1] || i2c_rd_tick;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_write <= 1'b0;
      r_reg   <= 8'h00;
      r_cnt   <= 4'd0;
      r_tmo   <= '0;
    end else begin
      if (w_arb_take) begin
        r_owner <= w_arb_idx;
        r_write <= w_arb_idx ? req_write[1] : req_write[0];
        r_reg   <= w_arb_idx ? req_reg[15:8] : req_reg[7:0];
        r_cnt   <= w_arb_len;
      end else if (w_byte_done) begin
        r_cnt   <= r_cnt - 4'd1;
      end
      if (w_tmo_clr) r_tmo <= '0;
      else           r_tmo <= r_tmo + TW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (|req_valid) w_next = ARB;
      ARB:    if (w_arb_gnt == 2'b00 || !w_len_ok) w_next = IDLE;
              else                                  w_next = DEV_W;
      DEV_W:  if (w_bus_fail) w_next = IDLE;
              else if (w_ack) w_next = REG;
      REG:    if (w_bus_fail) w_next = IDLE;
              else if (w_ack) w_next = r_write ? WDATA : RSTART;
      WDATA:  if (w_bus_fail || (w_ack && w_last)) w_next = IDLE;
      RSTART: if (i2c_rd_tick) w_next = w_last ? IDLE : RDATA;
              else if (w_rd_fail) w_next = IDLE;
      RDATA:  if ((i2c_rd_tick && w_last) || w_rd_fail) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Mealy outputs so ack/tick responses land in the same cycle as the event.
  always_comb begin
    grant       = 2'b00;
    wr_next     = 2'b00;
    rd_byte     = 8'h00;
    rd_valid    = 2'b00;
    done        = 2'b00;
    err         = 2'b00;
    i2c_start   = 1'b0;
    i2c_stop    = 1'b0;
    i2c_wr_data = 8'h00;
    if (!rst) begin
      case (r_state)
        ARB: begin
          grant = w_arb_gnt;
          if (!w_len_ok) begin
            done = w_arb_gnt;
            err  = w_arb_gnt;
          end
        end
        DEV_W: begin
          grant       = w_own_oh;
          i2c_start   = 1'b1;
          i2c_wr_data = {DEV_ADDR, 1'b0};
          if (w_bus_fail) begin
            i2c_stop = 1'b1;
            done     = w_own_oh;
            err      = w_own_oh;
          end
        end
        REG: begin
          grant       = w_own_oh;
          i2c_wr_data = r_reg;
          if (w_bus_fail) begin
            i2c_stop = 1'b1;
            done     = w_own_oh;
            err      = w_own_oh;
          end else if (w_ack && !r_write) begin
            i2c_start = 1'b1;
          end
        end
        WDATA: begin
          grant       = w_own_oh;
          i2c_wr_data = w_wr_sel;
          if (w_bus_fail) begin
            i2c_stop = 1'b1;
            done     = w_own_oh;
            err      = w_own_oh;
          end else if (w_ack) begin
            wr_next = w_own_oh;
            if (w_last) begin
              i2c_stop = 1'b1;
              done     = w_own_oh;
            end
          end
        end
        RSTART, RDATA: begin
          grant = w_own_oh;
          if (r_state == RSTART) i2c_wr_data = {DEV_ADDR, 1'b1};
          if (i2c_rd_tick) begin
            rd_valid = w_own_oh;
            rd_byte  = i2c_rd_data;
            if (w_last) begin
              i2c_stop = 1'b1;
              done     = w_own_oh;
            end
          end else if (w_rd_fail) begin
            i2c_stop = 1'b1;
            done     = w_own_oh;
            err      = w_own_oh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
